// File: rtl/lmac_fifo_pkg.sv
// Shared FIFO defaults and the helper that derives the pointer width from the depth.
package lmac_fifo_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_DEPTH = 16;

    function automatic int ptr_bits(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// FIFO storage: one synchronous write port and one combinational read port.
// There is no reset; contents are only ever qualified by the pointers in sync_fifo.
module sync_fifo_ram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int PTR   = 4
) (
    input  logic             clk,
    input  logic             we,
    input  logic [PTR-1:0]   waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [PTR-1:0]   raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/sync_fifo.sv
// Synchronous FIFO: pointers, occupancy, flags and sticky error bits around sync_fifo_ram.
// Define SYNC_FIFO_SHOWAHEAD_EN for first-word-fall-through output; default is registered read.
module sync_fifo
    import lmac_fifo_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int DEPTH     = DEFAULT_DEPTH,
    parameter int PTR       = ptr_bits(DEPTH),
    parameter int AFULL_TH  = 12,
    parameter int AEMPTY_TH = 2
) (
    input  logic             clk,
    input  logic             reset_,
    input  logic             wren,
    input  logic [WIDTH-1:0] datain,
    input  logic             rden,
    output logic [WIDTH-1:0] dataout,
    output logic             dvalid,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [PTR:0]     usedw,
    output logic             overflow,
    output logic             underflow,
    input  logic             clr_err
);

    localparam logic [PTR:0] DEPTH_C  = (PTR+1)'(DEPTH);
    localparam logic [PTR:0] AFULL_C  = (PTR+1)'(AFULL_TH);
    localparam logic [PTR:0] AEMPTY_C = (PTR+1)'(AEMPTY_TH);
    localparam logic [PTR:0] ONE_C    = (PTR+1)'(1);

    // Handshake: wren/rden are requests with no back-pressure other than the
    // registered flags; a write is taken only if !full and a read only if !empty,
    // both judged on the flags as they stand before the edge.
    logic             wr_acc, rd_acc;
    logic [PTR:0]     wr_ptr_d, wr_ptr_q, rd_ptr_d, rd_ptr_q;
    logic [PTR:0]     usedw_d, usedw_q;
    logic             full_d, full_q, empty_d, empty_q;
    logic             afull_d, afull_q, aempty_d, aempty_q;
    logic             overflow_d, overflow_q, underflow_d, underflow_q;
    logic [WIDTH-1:0] ram_rdata;

    sync_fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .PTR   (PTR)
    ) u_ram (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wr_ptr_q[PTR-1:0]),
        .wdata (datain),
        .raddr (rd_ptr_q[PTR-1:0]),
        .rdata (ram_rdata)
    );

    always_comb begin
        wr_acc   = wren && !full_q;
        rd_acc   = rden && !empty_q;
        wr_ptr_d = wr_acc ? wr_ptr_q + ONE_C : wr_ptr_q;
        rd_ptr_d = rd_acc ? rd_ptr_q + ONE_C : rd_ptr_q;
        usedw_d  = usedw_q;
        case ({wr_acc, rd_acc})
            2'b10:   usedw_d = usedw_q + ONE_C;
            2'b01:   usedw_d = usedw_q - ONE_C;
            default: usedw_d = usedw_q;
        endcase
        // Flags are derived from the next occupancy so they register alongside usedw.
        full_d      = (usedw_d == DEPTH_C);
        empty_d     = (usedw_d == '0);
        afull_d     = (usedw_d >= AFULL_C);
        aempty_d    = (usedw_d <= AEMPTY_C);
        overflow_d  = (wren && full_q)  || (overflow_q  && !clr_err);
        underflow_d = (rden && empty_q) || (underflow_q && !clr_err);
    end

    always_ff @(posedge clk) begin
        if (!reset_) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            usedw_q     <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            afull_q     <= 1'b0;
            aempty_q    <= 1'b1;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            usedw_q     <= usedw_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
            afull_q     <= afull_d;
            aempty_q    <= aempty_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

`ifdef SYNC_FIFO_SHOWAHEAD_EN
    // Head entry is shown directly from storage; zero while nothing is stored.
    assign dataout = empty_q ? '0 : ram_rdata;
    assign dvalid  = !empty_q;
`else
    logic [WIDTH-1:0] dataout_d, dataout_q;
    logic             dvalid_d, dvalid_q;

    always_comb begin
        dataout_d = rd_acc ? ram_rdata : dataout_q;
        dvalid_d  = rd_acc;
    end

    always_ff @(posedge clk) begin
        if (!reset_) begin
            dataout_q <= '0;
            dvalid_q  <= 1'b0;
        end else begin
            dataout_q <= dataout_d;
            dvalid_q  <= dvalid_d;
        end
    end

    assign dataout = dataout_q;
    assign dvalid  = dvalid_q;
`endif

    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = afull_q;
    assign almost_empty = aempty_q;
    assign usedw        = usedw_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo.sv
// Bench for sync_fifo: queue-based reference model checked every cycle, plus
// directed sequences with hand-computed expectations and a randomized phase.
module tb_sync_fifo;

    localparam int WIDTH     = 8;
    localparam int DEPTH     = 16;
    localparam int PTR       = 4;
    localparam int AFULL_TH  = 12;
    localparam int AEMPTY_TH = 2;

    logic             clk = 1'b0;
    logic             reset_;
    logic             wren;
    logic [WIDTH-1:0] datain;
    logic             rden;
    logic [WIDTH-1:0] dataout;
    logic             dvalid;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic [PTR:0]     usedw;
    logic             overflow;
    logic             underflow;
    logic             clr_err;

    sync_fifo #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .PTR       (PTR),
        .AFULL_TH  (AFULL_TH),
        .AEMPTY_TH (AEMPTY_TH)
    ) dut (
        .clk          (clk),
        .reset_       (reset_),
        .wren         (wren),
        .datain       (datain),
        .rden         (rden),
        .dataout      (dataout),
        .dvalid       (dvalid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .usedw        (usedw),
        .overflow     (overflow),
        .underflow    (underflow),
        .clr_err      (clr_err)
    );

    // Clock / reset block
    always #5 clk = ~clk;

    int n_compared   = 0;
    int n_mismatched = 0;
    bit check_en     = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the FIFO is a queue; outputs follow from its size and contents.
    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] exp_dout   = '0;
    bit               exp_dvalid = 1'b0;
    bit               exp_ovf    = 1'b0;
    bit               exp_udf    = 1'b0;

    always @(posedge clk) begin
        int sz;
        bit wr_ok, rd_ok;
        sz = exp_q.size();
        if (!reset_) begin
            exp_q.delete();
            exp_dout   = '0;
            exp_dvalid = 1'b0;
            exp_ovf    = 1'b0;
            exp_udf    = 1'b0;
        end else begin
            wr_ok      = wren && (sz < DEPTH);
            rd_ok      = rden && (sz > 0);
            exp_ovf    = (wren && sz == DEPTH) || (exp_ovf && !clr_err);
            exp_udf    = (rden && sz == 0) || (exp_udf && !clr_err);
            exp_dvalid = rd_ok;
            if (rd_ok) exp_dout = exp_q.pop_front();
            if (wr_ok) exp_q.push_back(datain);
        end
    end

    // Scoreboard compare on the falling edge
    always @(negedge clk) begin
        int sz;
        if (check_en) begin
            sz = exp_q.size();
            check("usedw", usedw, sz);
            check("full", full, sz == DEPTH);
            check("empty", empty, sz == 0);
            check("almost_full", almost_full, sz >= AFULL_TH);
            check("almost_empty", almost_empty, sz <= AEMPTY_TH);
            check("overflow", overflow, exp_ovf);
            check("underflow", underflow, exp_udf);
`ifdef SYNC_FIFO_SHOWAHEAD_EN
            check("dataout", dataout, (sz > 0) ? exp_q[0] : '0);
            check("dvalid", dvalid, sz > 0);
`else
            check("dataout", dataout, exp_dout);
            check("dvalid", dvalid, exp_dvalid);
`endif
        end
    end

    // Driver tasks
    task automatic cycle(input bit w, input logic [WIDTH-1:0] d, input bit r, input bit c);
        wren    = w;
        datain  = d;
        rden    = r;
        clr_err = c;
        @(posedge clk);
        #1;
        wren    = 1'b0;
        rden    = 1'b0;
        clr_err = 1'b0;
    endtask

    // Registered-read literal checks; in show-ahead mode the model compare covers dataout.
    task automatic check_read(input string name, input logic [WIDTH-1:0] val);
`ifndef SYNC_FIFO_SHOWAHEAD_EN
        check({name, "_data"}, dataout, val);
        check({name, "_dvalid"}, dvalid, 1'b1);
`endif
    endtask

    task automatic check_hold(input string name, input logic [WIDTH-1:0] val);
`ifndef SYNC_FIFO_SHOWAHEAD_EN
        check({name, "_data"}, dataout, val);
        check({name, "_dvalid"}, dvalid, 1'b0);
`endif
    endtask

    initial begin
        int wp, rp;
        reset_  = 1'b0;
        wren    = 1'b0;
        rden    = 1'b0;
        clr_err = 1'b0;
        datain  = '0;
        @(posedge clk);
        #1;
        check_en = 1'b1;
        cycle(1'b1, 8'hEE, 1'b1, 1'b0);
        reset_ = 1'b1;

        check("rst_usedw", usedw, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_aempty", almost_empty, 1);
        check("rst_dataout", dataout, 0);

        // Fill 0x01..0x10
        for (int i = 1; i <= 16; i++) begin
            cycle(1'b1, 8'(i), 1'b0, 1'b0);
            if (i == 11) check("afull_at_11", almost_full, 0);
            if (i == 12) check("afull_at_12", almost_full, 1);
        end
        check("fill_full", full, 1);
        check("fill_usedw", usedw, 16);
        for (int i = 1; i <= 16; i++) begin
            cycle(1'b0, '0, 1'b1, 1'b0);
            check_read("drain1", 8'(i));
        end
        check("drain1_empty", empty, 1);
        check("drain1_usedw", usedw, 0);

        // Overflow: 0xAA must be dropped
        for (int i = 1; i <= 16; i++) cycle(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
        cycle(1'b1, 8'hAA, 1'b0, 1'b0);
        check("ovf_set", overflow, 1);
        check("ovf_usedw", usedw, 16);
        cycle(1'b0, '0, 1'b0, 1'b1);
        check("ovf_clr", overflow, 0);
        for (int i = 1; i <= 16; i++) begin
            cycle(1'b0, '0, 1'b1, 1'b0);
            check_read("drain2", 8'(8'h20 + i));
        end

        // Underflow and simultaneous write+read on empty
        cycle(1'b0, '0, 1'b1, 1'b0);
        check("udf_set", underflow, 1);
        check_hold("udf", 8'h30);
        cycle(1'b1, 8'h55, 1'b1, 1'b0);
        check("wr_rd_empty_usedw", usedw, 1);
        check_hold("wr_rd_empty", 8'h30);
        cycle(1'b0, '0, 1'b0, 1'b1);
        check("udf_clr", underflow, 0);

        // Steady occupancy of 8 through pointer wraps
        for (int i = 1; i <= 7; i++) cycle(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
        check("steady_start_usedw", usedw, 8);
        for (int i = 1; i <= 40; i++) begin
            cycle(1'b1, 8'(8'h80 + i), 1'b1, 1'b0);
            if (i == 1) check_read("steady_first", 8'h55);
            if (i == 9) check_read("steady_ninth", 8'h81);
        end
        check("steady_usedw", usedw, 8);

        // Mid-operation reset with active requests
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, 1'b0);
        check("pre_reset_usedw", usedw, 5);
        reset_ = 1'b0;
        cycle(1'b1, 8'h99, 1'b1, 1'b0);
        reset_ = 1'b1;
        check("midrst_usedw", usedw, 0);
        check("midrst_empty", empty, 1);
        check("midrst_ovf", overflow, 0);
        check("midrst_udf", underflow, 0);
        cycle(1'b1, 8'h77, 1'b0, 1'b0);
`ifdef SYNC_FIFO_SHOWAHEAD_EN
        check("fwft_data", dataout, 8'h77);
        check("fwft_dvalid", dvalid, 1);
`endif
        cycle(1'b0, '0, 1'b1, 1'b0);
        check_read("post_reset", 8'h77);
        check("post_reset_usedw", usedw, 0);

`ifdef SYNC_FIFO_SHOWAHEAD_EN
        cycle(1'b1, 8'h5A, 1'b0, 1'b0);
        check("sa_5a_data", dataout, 8'h5A);
        check("sa_5a_dvalid", dvalid, 1);
        cycle(1'b0, '0, 1'b1, 1'b0);
`endif

        // Randomized phase with shifting write/read bias
        for (int blk = 0; blk < 10; blk++) begin
            wp = $urandom_range(10, 90);
            rp = $urandom_range(10, 90);
            for (int i = 0; i < 200; i++) begin
                reset_ = ($urandom_range(0, 499) != 0);
                cycle($urandom_range(0, 99) < wp, 8'($urandom), $urandom_range(0, 99) < rp,
                      $urandom_range(0, 31) == 0);
                reset_ = 1'b1;
            end
        end

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
